// File: rtl/full_adder_4bit_sync.sv
// Registered 4-bit ripple-carry adder with carry, signed-overflow and zero flags.
// A result is presented one clock after its operands, qualified by out_valid.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_c,
  output logic cout_c
);

  // One bit of the ripple chain
  always_comb begin
    sum_c  = a ^ b ^ cin;
    cout_c = (a & b) | (cin & (a ^ b));
  end

endmodule

module full_adder_4bit_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out,
  output logic       overflow,
  output logic       zero,
  output logic       out_valid
);

  localparam int unsigned W = 4;

  logic [W:0]   carry;
  logic [W-1:0] sum_next;

  assign carry[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_cell
    full_adder_cell u_cell (
      .a      (a[i]),
      .b      (b[i]),
      .cin    (carry[i]),
      .sum_c  (sum_next[i]),
      .cout_c (carry[i+1])
    );
  end

  // Result flags update only on accepted operands; out_valid tracks in_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= sum_next;
        c_out    <= carry[W];
        overflow <= carry[W-1] ^ carry[W];
        zero     <= ~|sum_next;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_4bit_sync.sv
// Self-checking bench for full_adder_4bit_sync: directed table, hold, exhaustive,
// randomized and mid-stream reset sequences against an arithmetic reference model.

module tb_full_adder_4bit_sync;

  typedef struct packed {
    logic [3:0] sum;
    logic       co;
    logic       ovf;
    logic       zero;
  } res_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] sum;
    logic       co;
    logic       ovf;
    logic       zero;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic [3:0] sum;
  logic       c_out;
  logic       overflow;
  logic       zero;
  logic       out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  res_t exp_r;
  logic exp_v;
  vec_t tbl [7];

  full_adder_4bit_sync dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference: exact unsigned and signed sums, flags derived from their ranges
  function automatic res_t model(input logic [3:0] x, input logic [3:0] y, input logic ci);
    res_t r;
    int   u;
    int   s;
    u = int'(x) + int'(y) + int'(ci);
    s = int'($signed(x)) + int'($signed(y)) + int'(ci);
    r.sum  = 4'(u);
    r.co   = (u > 15);
    r.ovf  = (s > 7) || (s < -8);
    r.zero = ((u % 16) == 0);
    return r;
  endfunction

  task automatic check1(input string name, input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_all(input string tag, input res_t r, input logic v);
    check1({tag, ".sum"},       sum,             r.sum);
    check1({tag, ".c_out"},     {3'b0, c_out},    {3'b0, r.co});
    check1({tag, ".overflow"},  {3'b0, overflow}, {3'b0, r.ovf});
    check1({tag, ".zero"},      {3'b0, zero},     {3'b0, r.zero});
    check1({tag, ".out_valid"}, {3'b0, out_valid}, {3'b0, v});
  endtask

  // Drive one cycle of inputs on the falling edge, sample just after the rising edge
  task automatic step(input logic r, input logic iv, input logic [3:0] x,
                      input logic [3:0] y, input logic ci);
    @(negedge clk);
    rst = r; in_valid = iv; a = x; b = y; c_in = ci;
    @(posedge clk);
    #1;
    if (r) begin
      exp_r = '0;
      exp_v = 1'b0;
    end else begin
      exp_v = iv;
      if (iv) exp_r = model(x, y, ci);
    end
  endtask

  initial begin
    tbl[0] = '{a: 4'd0,  b: 4'd0,  ci: 1'b0, sum: 4'd0,  co: 1'b0, ovf: 1'b0, zero: 1'b1};
    tbl[1] = '{a: 4'd4,  b: 4'd5,  ci: 1'b1, sum: 4'd10, co: 1'b0, ovf: 1'b1, zero: 1'b0};
    tbl[2] = '{a: 4'd10, b: 4'd6,  ci: 1'b0, sum: 4'd0,  co: 1'b1, ovf: 1'b0, zero: 1'b1};
    tbl[3] = '{a: 4'd10, b: 4'd6,  ci: 1'b1, sum: 4'd1,  co: 1'b1, ovf: 1'b0, zero: 1'b0};
    tbl[4] = '{a: 4'd15, b: 4'd15, ci: 1'b1, sum: 4'd15, co: 1'b1, ovf: 1'b0, zero: 1'b0};
    tbl[5] = '{a: 4'd7,  b: 4'd1,  ci: 1'b0, sum: 4'd8,  co: 1'b0, ovf: 1'b1, zero: 1'b0};
    tbl[6] = '{a: 4'd3,  b: 4'd4,  ci: 1'b0, sum: 4'd7,  co: 1'b0, ovf: 1'b0, zero: 1'b0};

    rst = 1'b1; in_valid = 1'b1; a = 4'd15; b = 4'd15; c_in = 1'b1;
    exp_r = '0; exp_v = 1'b0;

    // Reset held two cycles with live operands
    step(1'b1, 1'b1, 4'd15, 4'd15, 1'b1);
    step(1'b1, 1'b1, 4'd15, 4'd15, 1'b1);
    check_all("reset", '0, 1'b0);

    // Directed table, hand-computed expectations
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].ci);
      check_all($sformatf("vec%0d", i),
                '{sum: tbl[i].sum, co: tbl[i].co, ovf: tbl[i].ovf, zero: tbl[i].zero}, 1'b1);
    end

    // Idle cycles after 3+4: flags hold, out_valid drops
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
      check_all($sformatf("hold%0d", i),
                '{sum: 4'd7, co: 1'b0, ovf: 1'b0, zero: 1'b0}, 1'b0);
    end

    // Exhaustive back-to-back
    for (int i = 0; i < 512; i++) begin
      step(1'b0, 1'b1, 4'(i), 4'(i >> 4), 1'(i >> 8));
      check_all($sformatf("exh%0d", i), exp_r, 1'b1);
    end

    // Randomized stream with gaps and occasional reset
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      check_all($sformatf("rnd%0d", i), exp_r, exp_v);
    end

    // Reset pulsed mid-stream discards the operand set presented with it
    step(1'b0, 1'b1, 4'd9, 4'd9, 1'b0);
    check_all("mid.pre", '{sum: 4'd2, co: 1'b1, ovf: 1'b1, zero: 1'b0}, 1'b1);
    step(1'b1, 1'b1, 4'd5, 4'd5, 1'b1);
    check_all("mid.rst", '0, 1'b0);
    step(1'b0, 1'b1, 4'd2, 4'd3, 1'b1);
    check_all("mid.resume", '{sum: 4'd6, co: 1'b0, ovf: 1'b0, zero: 1'b0}, 1'b1);
    step(1'b0, 1'b1, 4'd8, 4'd8, 1'b0);
    check_all("mid.next", '{sum: 4'd0, co: 1'b1, ovf: 1'b1, zero: 1'b1}, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
